// File: rtl/seg_scan_receiver_if.sv
// Seven-segment scan bus: active-low anode/segment lines toward the receiver,
// published frame fields back from it.
interface seg_scan_receiver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;

  modport master (
    output an, seg,
    input  digits, dp, digit_err, frame_valid
  );

  modport slave (
    input  an, seg,
    output digits, dp, digit_err, frame_valid
  );
endinterface

// File: rtl/seg_scan_receiver.sv
// Samples a multiplexed seven-segment display bus, waits for each digit to settle,
// decodes it and publishes one coherent frame once every position has been captured.
module seg_scan_receiver #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst,
  seg_scan_receiver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  localparam logic [7:0]            SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT_LSB = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0]   an_meta, an_sync, an_prev;
  logic [7:0]              seg_meta, seg_sync, seg_prev;

  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    capture;

  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic                    sel_valid;
  logic                    same_sample;
  logic [3:0]              dec_val;
  logic                    dec_err;

  logic [NUM_DIGITS-1:0]   seen, seen_n;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] stage_val;
  logic [NUM_DIGITS-1:0]   stage_dp;
  logic [NUM_DIGITS-1:0]   stage_err;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   digit_err_q;
  logic                    frame_valid_q;

  // Exact match on segments a..g; anything else is reported as an illegal digit.
  function automatic logic [4:0] decode_seg(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      7'h40:   result = {1'b0, 4'd0};
      7'h79:   result = {1'b0, 4'd1};
      7'h24:   result = {1'b0, 4'd2};
      7'h30:   result = {1'b0, 4'd3};
      7'h19:   result = {1'b0, 4'd4};
      7'h12:   result = {1'b0, 4'd5};
      7'h02:   result = {1'b0, 4'd6};
      7'h78:   result = {1'b0, 4'd7};
      7'h00:   result = {1'b0, 4'd8};
      7'h10:   result = {1'b0, 4'd9};
      default: result = {1'b1, 4'hF};
    endcase
    return result;
  endfunction

  // The prev stage holds the previous synchronized sample for settle comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta  <= '0;
      an_sync  <= '0;
      an_prev  <= '0;
      seg_meta <= '0;
      seg_sync <= '0;
      seg_prev <= '0;
    end else begin
      an_meta  <= bus.an;
      an_sync  <= an_meta;
      an_prev  <= an_sync;
      seg_meta <= bus.seg;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
    end
  end

  always_comb begin
    sel_onehot  = ~an_sync;
    sel_valid   = (sel_onehot != '0) &&
                  ((sel_onehot & (sel_onehot - ONE_HOT_LSB)) == '0);
    same_sample = ({an_sync, seg_sync} == {an_prev, seg_prev});
    {dec_err, dec_val} = decode_seg(seg_sync[6:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt counts identical samples; the capture fires on the edge it reaches SETTLE_MAX.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_n = SETTLE;
          cnt_n   = 8'd1;
        end
      end
      SETTLE: begin
        if (!sel_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!same_sample) begin
          cnt_n = 8'd1;
        end else if (cnt >= SETTLE_MAX - 8'd1) begin
          capture = 1'b1;
          state_n = HELD;
          cnt_n   = SETTLE_MAX;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      HELD: begin
        if (!same_sample) begin
          if (sel_valid) begin
            state_n = SETTLE;
            cnt_n   = 8'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A capture on the publish edge lands after the clear and starts the next frame.
  always_comb begin
    frame_ready = &seen;
    seen_n      = frame_ready ? '0 : seen;
    if (capture) begin
      seen_n = seen_n | sel_onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen      <= '0;
      stage_val <= '0;
      stage_dp  <= '0;
      stage_err <= '0;
    end else begin
      seen <= seen_n;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_onehot[i]) begin
          stage_val[4*i +: 4] <= dec_val;
          stage_dp[i]         <= ~seg_sync[7];
          stage_err[i]        <= dec_err;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q      <= '0;
      dp_q          <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_ready;
      if (frame_ready) begin
        digits_q    <= stage_val;
        dp_q        <= stage_dp;
        digit_err_q <= stage_err;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.frame_valid = frame_valid_q;

endmodule
